// File: rtl/ram_rr_arbiter_pkg.sv
// Shared types for the two-requester RAM arbiter.
// Owner encoding, lock FSM states and default widths.
package ram_arb_pkg;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 4;
  localparam int LOCK_MAX_D = 4;

  typedef logic [1:0] owner_t;

  localparam owner_t OWN_NONE = 2'b00;
  localparam owner_t OWN_A    = 2'b01;
  localparam owner_t OWN_B    = 2'b10;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_LOCKED_A = 2'b01,
    ST_LOCKED_B = 2'b10
  } lock_st_t;

  function automatic owner_t st_owner(
    input lock_st_t s
  );
    unique case (s)
      ST_LOCKED_A: return OWN_A;
      ST_LOCKED_B: return OWN_B;
      default:     return OWN_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ram_rr_arbiter_if.sv
// One requester channel: valid/ready request plus
// a non-backpressured read response. master = client.
interface ram_rr_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = ADDR_W
);

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic          req_lock;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_lock,
    output req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_lock,
    input  req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/ram_rr_arbiter_rr_arb2.sv
// Combinational two-way grant: lock owner first, then
// a lone requester, then the round-robin pointer.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_rr_ptr,
  input  owner_t     i_lock_owner,
  output logic [1:0] o_gnt
);

  logic [1:0] w_own;

  assign w_own = i_lock_owner & i_req;

  always_comb begin
    o_gnt = 2'b00;
    if (|w_own) begin
      o_gnt = w_own;
    end else if (&i_req) begin
      o_gnt = i_rr_ptr ? 2'b10 : 2'b01;
    end else begin
      o_gnt = i_req;
    end
  end

endmodule

// File: rtl/ram_rr_arbiter.sv
// Shares one 1-cycle-latency single-port RAM between
// requesters a/b (slave channels); drives all ram_* pins.
module ram_rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int LOCK_MAX   = LOCK_MAX_D
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_rr_arbiter_if.slave       a,
  ram_rr_arbiter_if.slave       b,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(LOCK_MAX - 1);

  lock_st_t    r_st, w_st_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic        r_rr_ptr, w_rr_nxt;
  owner_t      r_tag, w_tag_nxt;
  owner_t      w_owner;
  logic [1:0]  w_req, w_gnt;
  logic        w_any, w_idx;
  logic        w_lock_g, w_we_g, w_own_g;

  // Nothing is granted while reset is held.
  assign w_req   = rst ? 2'b00
                 : {b.req_valid, a.req_valid};
  assign w_owner = st_owner(r_st);

  rr_arb2 u_arb (
    .i_req        (w_req),
    .i_rr_ptr     (r_rr_ptr),
    .i_lock_owner (w_owner),
    .o_gnt        (w_gnt)
  );

  assign w_any    = |w_gnt;
  assign w_idx    = w_gnt[1];
  assign w_lock_g = w_idx ? b.req_lock : a.req_lock;
  assign w_we_g   = w_idx ? b.req_we : a.req_we;
  assign w_own_g  = w_any && (w_gnt == w_owner);

  assign a.req_ready = w_gnt[0];
  assign b.req_ready = w_gnt[1];

  always_comb begin
    ram_en   = w_any;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    if (w_gnt[0]) begin
      ram_we   = a.req_we;
      ram_addr = a.req_addr;
      ram_din  = a.req_wdata;
    end else if (w_gnt[1]) begin
      ram_we   = b.req_we;
      ram_addr = b.req_addr;
      ram_din  = b.req_wdata;
    end
  end

  // Pointer always lands on the loser; a locked
  // owner's grants leave it there, so the release
  // hands priority to the other side.
  always_comb begin
    w_st_nxt  = r_st;
    w_cnt_nxt = r_cnt;
    w_rr_nxt  = r_rr_ptr;
    w_tag_nxt = w_we_g ? OWN_NONE : owner_t'(w_gnt);
    if (w_any) w_rr_nxt = ~w_idx;
    if (w_own_g) begin
      if (w_lock_g && (r_cnt < CNT_LAST)) begin
        w_cnt_nxt = r_cnt + CW'(1);
      end else begin
        w_st_nxt  = ST_UNLOCKED;
        w_cnt_nxt = '0;
      end
    end else if (w_any && w_lock_g
                 && (LOCK_MAX > 1)) begin
      w_st_nxt  = w_idx ? ST_LOCKED_B : ST_LOCKED_A;
      w_cnt_nxt = CW'(1);
    end else begin
      // No grant, or an idle owner lost the lock.
      w_st_nxt  = ST_UNLOCKED;
      w_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st     <= ST_UNLOCKED;
      r_cnt    <= '0;
      r_rr_ptr <= 1'b0;
      r_tag    <= OWN_NONE;
    end else begin
      r_st     <= w_st_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rr_ptr <= w_rr_nxt;
      r_tag    <= w_tag_nxt;
    end
  end

  assign a.rsp_valid = r_tag[0];
  assign b.rsp_valid = r_tag[1];
  assign a.rsp_rdata = r_tag[0] ? ram_dout : '0;
  assign b.rsp_rdata = r_tag[1] ? ram_dout : '0;

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Scoreboard bench for ram_rr_arbiter: directed
// scenarios plus randomized traffic with resets.
module tb_ram_rr_arbiter;
  import ram_arb_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int LM = 4;
  localparam int NW = 1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ram_rr_arbiter_if #(.DW(DW), .AW(AW)) a_if ();
  ram_rr_arbiter_if #(.DW(DW), .AW(AW)) b_if ();

  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;
  logic [DW-1:0] mem [NW] = '{default: '0};

  ram_rr_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .LOCK_MAX   (LM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a_if),
    .b        (b_if),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      else ram_dout <= mem[ram_addr];
    end
  end

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  typedef struct {
    logic          we;
    logic          lock;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            gap;
  } req_t;

  rsp_t qa[$], qb[$];
  req_t ra[$], rb[$];

  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  logic  a_fire = 1'b0;
  logic  b_fire = 1'b0;
  string glog = "";
  int    rlog[$];

  // Reference: who owns a lock, how many grants it
  // has taken in a row, who wins the next tie.
  int m_owner = 0;
  int m_run = 0;
  int m_next = 0;
  logic [DW-1:0] shadow [NW] = '{default: '0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h cyc %0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic chk_s(input string nm,
                       input string act,
                       input string exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %s expected %s",
               nm, act, exp);
    end
  endtask

  task automatic rsp_chk(input int port,
                         input string nm,
                         input logic v,
                         input logic [DW-1:0] d);
    rsp_t e;
    int   n;
    n = (port == 0) ? qa.size() : qb.size();
    if (v) begin
      if (n == 0) begin
        chk({nm, "_spurious"}, 32'(v), 32'(0));
      end else begin
        if (port == 0) e = qa.pop_front();
        else e = qb.pop_front();
        chk({nm, "_data"}, 32'(d), 32'(e.data));
        chk({nm, "_time"}, cyc, e.due);
        rlog.push_back(port * 256 + int'(d));
      end
    end else begin
      chk({nm, "_idle"}, 32'(d), 32'(0));
      if (n > 0) begin
        if (port == 0) e = qa[0];
        else e = qb[0];
        if (e.due <= cyc) begin
          if (port == 0) void'(qa.pop_front());
          else void'(qb.pop_front());
          chk({nm, "_missing"}, 32'(v), 32'(1));
        end
      end
    end
  endtask

  always @(negedge clk) begin : mon
    logic          va, vb, lk, gw;
    logic [AW-1:0] gad;
    logic [DW-1:0] gd;
    rsp_t          r;
    int            eg;
    va = a_if.req_valid;
    vb = b_if.req_valid;
    if (rst) eg = 0;
    else if (m_owner == 1 && va) eg = 1;
    else if (m_owner == 2 && vb) eg = 2;
    else if (va && vb) eg = (m_next == 0) ? 1 : 2;
    else if (va) eg = 1;
    else if (vb) eg = 2;
    else eg = 0;
    chk("grant",
        32'({b_if.req_ready, a_if.req_ready}), eg);
    a_fire = a_if.req_ready;
    b_fire = b_if.req_ready;
    if (eg == 1) glog = {glog, "A"};
    else if (eg == 2) glog = {glog, "B"};
    else glog = {glog, "-"};
    chk("ram_en", 32'(ram_en), 32'(eg != 0));
    rsp_chk(0, "rsp_a", a_if.rsp_valid,
            a_if.rsp_rdata);
    rsp_chk(1, "rsp_b", b_if.rsp_valid,
            b_if.rsp_rdata);
    if (eg != 0) begin
      gw  = (eg == 1) ? a_if.req_we : b_if.req_we;
      lk  = (eg == 1) ? a_if.req_lock : b_if.req_lock;
      gad = (eg == 1) ? a_if.req_addr : b_if.req_addr;
      gd  = (eg == 1) ? a_if.req_wdata
                      : b_if.req_wdata;
      chk("ram_bus",
          32'({ram_we, ram_addr, ram_din}),
          32'({gw, gad, gd}));
      if (gw) begin
        shadow[gad] = gd;
      end else begin
        r.due  = cyc + 1;
        r.data = shadow[gad];
        if (eg == 1) qa.push_back(r);
        else qb.push_back(r);
      end
      m_next = (eg == 1) ? 1 : 0;
      if (m_owner == eg) begin
        if (lk && (m_run + 1 < LM)) begin
          m_run++;
        end else begin
          m_owner = 0;
          m_run   = 0;
        end
      end else if (lk && LM > 1) begin
        m_owner = eg;
        m_run   = 1;
      end else begin
        m_owner = 0;
        m_run   = 0;
      end
    end else begin
      chk("ram_idle",
          32'({ram_we, ram_addr, ram_din}), 32'(0));
      m_owner = 0;
      m_run   = 0;
    end
    if (rst) begin
      m_owner = 0;
      m_run   = 0;
      m_next  = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    a_if.req_valid = 1'b0;
    a_if.req_we    = 1'b0;
    a_if.req_lock  = 1'b0;
    a_if.req_addr  = '0;
    a_if.req_wdata = '0;
    b_if.req_valid = 1'b0;
    b_if.req_we    = 1'b0;
    b_if.req_lock  = 1'b0;
    b_if.req_addr  = '0;
    b_if.req_wdata = '0;
  endtask

  function automatic req_t mk(input logic we,
                              input logic lock,
                              input int addr,
                              input int wdata,
                              input int gap);
    req_t r;
    r.we    = we;
    r.lock  = lock;
    r.addr  = AW'(addr);
    r.wdata = DW'(wdata);
    r.gap   = gap;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic run(input int maxc, input bit rr);
    int c  = 0;
    int ga = -1;
    int gb = -1;
    while ((ra.size() > 0 || rb.size() > 0)
           && c < maxc) begin
      if (ra.size() > 0 && ga < 0) ga = ra[0].gap;
      if (rb.size() > 0 && gb < 0) gb = rb[0].gap;
      a_if.req_valid = (ra.size() > 0) && (ga == 0);
      if (ra.size() > 0) begin
        a_if.req_we    = ra[0].we;
        a_if.req_lock  = ra[0].lock;
        a_if.req_addr  = ra[0].addr;
        a_if.req_wdata = ra[0].wdata;
      end
      b_if.req_valid = (rb.size() > 0) && (gb == 0);
      if (rb.size() > 0) begin
        b_if.req_we    = rb[0].we;
        b_if.req_lock  = rb[0].lock;
        b_if.req_addr  = rb[0].addr;
        b_if.req_wdata = rb[0].wdata;
      end
      rst = rr && ($urandom_range(0, 39) == 0);
      step();
      if (a_fire) begin
        void'(ra.pop_front());
        ga = -1;
      end else if (ga > 0) ga--;
      if (b_fire) begin
        void'(rb.pop_front());
        gb = -1;
      end else if (gb > 0) gb--;
      c++;
    end
    chk("run_done", ra.size() + rb.size(), 0);
    ra.delete();
    rb.delete();
    rst = 1'b0;
    idle_in();
    repeat (3) step();
  endtask

  initial begin
    int exp2[4];
    idle_in();
    do_reset();

    // write then read back on A only
    glog = "";
    rlog.delete();
    ra.push_back(mk(1, 0, 3, 'h5A, 0));
    ra.push_back(mk(0, 0, 3, 0, 0));
    run(20, 0);
    chk_s("s1_log", glog, "AA---");
    chk("s1_rsp", rlog.size() == 1 ? rlog[0] : -1,
        'h5A);

    // preload from B so the next tie goes to A
    rb.push_back(mk(1, 0, 1, 'h11, 0));
    rb.push_back(mk(1, 0, 2, 'h22, 0));
    run(20, 0);
    glog = "";
    rlog.delete();
    ra.push_back(mk(0, 0, 1, 0, 0));
    ra.push_back(mk(0, 0, 1, 0, 0));
    rb.push_back(mk(0, 0, 2, 0, 0));
    rb.push_back(mk(0, 0, 2, 0, 0));
    run(20, 0);
    chk_s("s2_log", glog, "ABAB---");
    exp2 = '{'h11, 'h122, 'h11, 'h122};
    chk("s2_nrsp", rlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("s2_rsp", i < rlog.size() ? rlog[i] : -1,
          exp2[i]);
    end

    // locked burst is capped at LOCK_MAX grants
    glog = "";
    for (int i = 0; i < 6; i++) begin
      ra.push_back(mk(1, i < 5, 8 + i, 'hA0 + i, 0));
    end
    rb.push_back(mk(0, 0, 5, 0, 0));
    run(30, 0);
    chk_s("s3_log", glog, "AAAABAA---");

    // idle owner drops lock, B gets the slot
    glog = "";
    rlog.delete();
    ra.push_back(mk(1, 1, 9, 'h99, 0));
    ra.push_back(mk(1, 0, 10, 'h77, 1));
    rb.push_back(mk(0, 0, 9, 0, 1));
    run(20, 0);
    chk_s("s4_log", glog, "ABA---");
    chk("s4_rsp", rlog.size() == 1 ? rlog[0] : -1,
        'h199);

    // same-cycle write/read after reset
    do_reset();
    glog = "";
    rlog.delete();
    ra.push_back(mk(1, 0, 7, 'hC3, 0));
    rb.push_back(mk(0, 0, 7, 0, 0));
    run(20, 0);
    chk_s("s5_log", glog, "AB---");
    chk("s5_rsp", rlog.size() == 1 ? rlog[0] : -1,
        'h1C3);

    // reset during a B read attempt
    glog = "";
    rlog.delete();
    a_if.req_valid = 1'b1;
    a_if.req_addr  = 4'd7;
    step();
    a_if.req_valid = 1'b0;
    b_if.req_valid = 1'b1;
    b_if.req_addr  = 4'd3;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("s6_no_brsp", 32'(b_if.rsp_valid), 32'(0));
    a_if.req_valid = 1'b1;
    a_if.req_addr  = 4'd1;
    b_if.req_addr  = 4'd2;
    step();
    a_if.req_valid = 1'b0;
    step();
    idle_in();
    repeat (3) step();
    chk_s("s6_log", glog, "A-AB---");
    chk("s6_nrsp", rlog.size(), 3);
    exp2 = '{'hC3, 'h11, 'h122, 0};
    for (int i = 0; i < 3; i++) begin
      chk("s6_rsp", i < rlog.size() ? rlog[i] : -1,
          exp2[i]);
    end

    // randomized traffic with sporadic resets
    for (int i = 0; i < 300; i++) begin
      ra.push_back(mk($urandom_range(0, 1),
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, NW - 1),
                      $urandom_range(0, 255),
                      $urandom_range(0, 2)));
      rb.push_back(mk($urandom_range(0, 1),
                      $urandom_range(0, 3) == 0,
                      $urandom_range(0, NW - 1),
                      $urandom_range(0, 255),
                      $urandom_range(0, 2)));
    end
    run(5000, 1);
    chk("drain", qa.size() + qb.size(), 0);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Round-robin arbiter that shares one synchronous single-port RAM (1-cycle read latency, en/we/addr/din/dout interface) between two requesters, A and B.
- Each requester gets a valid/ready request channel and a non-backpressured read-response channel.
- An optional lock lets the current owner keep the RAM for back-to-back accesses, for example read-modify-write.
- The block sits between client engines and the RAM macro. It owns every RAM control signal.

Parameters:
- DATA_WIDTH, 8, RAM word width
- ADDR_WIDTH, 4, RAM address width
- LOCK_MAX, 4, maximum consecutive grants a locked owner may take before it is forced to yield

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active high
- a_req_valid  in  1  requester A has an access pending
- a_req_ready  out  1  A's access is issued this cycle
- a_req_we  in  1  1 = write, 0 = read
- a_req_lock  in  1  request to keep the grant for the next access
- a_req_addr  in  ADDR_WIDTH  access address
- a_req_wdata  in  DATA_WIDTH  write data
- a_rsp_valid  out  1  read data for A valid this cycle
- a_rsp_rdata  out  DATA_WIDTH  read data for A
- b_req_valid, b_req_ready, b_req_we, b_req_lock, b_req_addr, b_req_wdata, b_rsp_valid, b_rsp_rdata: same as A, for requester B
- ram_en  out  1  RAM enable
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_din  out  DATA_WIDTH  RAM write data
- ram_dout  in  DATA_WIDTH  RAM read data, valid the cycle after a read issue

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active high, and takes effect only on a clk rising edge.
- Reset values:
  - rr_ptr = A (A has priority on the first contention).
  - lock_owner = NONE, lock_cnt = 0.
  - a_rsp_valid = b_rsp_valid = 0, response-pending flag cleared.
  - All ready outputs and ram_en are 0 while rst is high.
- Issue rule: at most one access per cycle. The grant is combinational from valid, rr_ptr and lock state.
  - ready = grant (same cycle), and the access is issued in that cycle.
  - ram_en = 1 only in an issue cycle; ram_we/addr/din are muxed from the granted requester.
  - When ram_en = 0, ram_we = 0 and addr/din are don't-care (driven 0).
- Arbitration, in priority order:
  1. lock_owner != NONE and the owner's valid = 1 → the owner is granted.
  2. Otherwise, only one requester valid → that requester is granted.
  3. Otherwise, both valid → the requester pointed to by rr_ptr is granted.
- rr_ptr update: on every unlocked grant, rr_ptr moves to the non-granted requester. It is unchanged when no grant is made.
- Lock FSM, states UNLOCKED and LOCKED_A/LOCKED_B:
  - UNLOCKED → LOCKED_X when X is granted with lock = 1; lock_cnt = 1.
  - LOCKED_X, X granted with lock = 1 and lock_cnt < LOCK_MAX-1 → stay; lock_cnt + 1.
  - LOCKED_X, X granted with lock = 0, or lock_cnt = LOCK_MAX-1 → UNLOCKED; rr_ptr = other requester.
  - LOCKED_X, X valid = 0 for one cycle → UNLOCKED (lock is dropped; an idle owner does not stall the other requester). The other requester can be granted in that same cycle.
- Read response:
  - A read issued in cycle N gives a_rsp_valid or b_rsp_valid = 1 in cycle N+1, for exactly one cycle.
  - rsp_rdata = ram_dout (passthrough) in that cycle; it holds 0 otherwise.
  - The owner is tracked by a 1-entry tag register.
  - No backpressure: requesters must accept the response.
- Writes produce no response. Write-then-read to the same address in consecutive cycles returns the new data, because the RAM write completes at edge N.
- Request stability: a requester must hold valid/addr/we/wdata/lock stable until ready. valid deasserting before ready is legal and cancels the access.
- Reset mid-operation:
  - A read issued in the cycle rst is sampled produces no response.
  - The lock and rr_ptr return to their reset values.
- A request may be granted every cycle. Sustained contention without lock alternates A, B, A, B.

Decomposition:
- Package ram_arb_pkg holds:
  - The owner encoding: NONE = 2'b00, A = 2'b01, B = 2'b10.
  - The lock FSM state enum.
  - The default-width localparams.
- Sub-module rr_arb2: combinational 2-way round-robin grant. Inputs: req[1:0], rr_ptr, lock_owner. Outputs: one-hot grant.
- The top level holds rr_ptr, the lock FSM, lock_cnt, the response tag register and the RAM mux.

Test Plan:
- Reset, then A writes addr 3 = 0x5A, then A reads addr 3 → a_req_ready is high the same cycle; a_rsp_valid pulses 1 cycle after the read issue with rdata 0x5A; b_rsp_valid stays 0.
- A and B both hold valid reads (A addr 1, B addr 2, preloaded 0x11/0x22) for 4 cycles → grants A, B, A, B; responses 0x11, 0x22, 0x11, 0x22 on the matching port one cycle later each.
- A asserts lock with 6 back-to-back writes while B is valid, LOCK_MAX = 4 → A is granted 4 consecutive cycles, then B is granted, then A.
- A locks, then drops valid for one cycle with B valid → B is granted in that cycle; the lock is released.
- Same cycle: A writes addr 7 = 0xC3, B reads addr 7 → A is granted first (rr_ptr = A after reset); B's read the next cycle returns 0xC3.
- rst asserted in the cycle a B read issues → no b_rsp_valid the next cycle; all outputs return to reset values; the next contention grants A first.
